// File: rtl/mem_sched_pkg.sv
// ============================================================================
// Module   : mem_sched_pkg
// Purpose  : Shared types and constants for the memory-port scheduler.
//            - state_e : scheduler FSM states
//            - owner_e : which cache owns the memory port
//            - other_owner() : returns the opposite owner
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam int LINE_BEATS_DFLT = 8;
  localparam int BEAT_CNT_W      = $clog2(LINE_BEATS_DFLT);

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IC) ? OWN_DC : OWN_IC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-requester round-robin pick. A lone requester always wins;
//            on a tie the requester that did not own the port last wins.
// Ports    : req_ic, req_dc  - request levels
//            last_owner      - owner of the most recent completed burst
//            any             - at least one request present
//            pick            - selected owner (valid when any=1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
  import mem_sched_pkg::*;
(
  input  logic   req_ic,
  input  logic   req_dc,
  input  owner_e last_owner,
  output logic   any,
  output owner_e pick
);

  always_comb begin
    any  = req_ic | req_dc;
    pick = OWN_IC;
    if (req_ic && req_dc) begin
      pick = other_owner(last_owner);
    end else if (req_dc) begin
      pick = OWN_DC;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_scheduler.sv
// ============================================================================
// Module   : mem_port_scheduler
// Purpose  : Shares one main-memory burst port between the I-cache (fills)
//            and the D-cache (fills and writebacks). Arbitration is done per
//            transaction (round-robin); the grant is held for the whole
//            LINE_BEATS burst, read beats / write-ready are steered to the
//            owner, and the owner's done pulses once the burst completes.
// Ports    : clk, reset (async, active-high)
//            ic_req/ic_addr                       - I-cache fill request
//            dc_req/dc_we/dc_addr/dc_wdata        - D-cache request
//            ic_grant/dc_grant                    - port ownership
//            rdata/ic_rvalid/dc_rvalid/dc_wready  - beat steering
//            ic_done/dc_done                      - burst completion pulses
//            mem_req_*/mem_w*/mem_r*              - memory bridge side
//            err                                  - watchdog abort pulse
// Options  : `define MPS_TIMEOUT_EN enables a REQ/XFER stall watchdog of
//            TIMEOUT_CYC cycles; without it err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int LINE_BEATS  = LINE_BEATS_DFLT,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              ic_grant,
  output logic              dc_grant,
  output logic [DATA_W-1:0] rdata,
  output logic              ic_rvalid,
  output logic              dc_rvalid,
  output logic              dc_wready,
  output logic              ic_done,
  output logic              dc_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              err
);

  // Byte offset bits inside one cache line; these are zeroed on the bus.
  localparam int OFFS  = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int CNT_W = $clog2(LINE_BEATS);

  state_e               state, state_nxt;
  owner_e               owner, last_owner, pick;
  logic                 any_req;
  logic                 we_q;
  logic [ADDR_W-OFFS-1:0] addr_hi;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 beat_fire;
  logic                 last_beat;
  logic                 timeout;

  rr_pick2 u_pick (
    .req_ic     (ic_req),
    .req_dc     (dc_req),
    .last_owner (last_owner),
    .any        (any_req),
    .pick       (pick)
  );

  // A beat moves on the read or write channel depending on burst direction.
  assign beat_fire = (state == XFER) && (we_q ? mem_wready : mem_rvalid);
  assign last_beat = (beat_cnt == CNT_W'(LINE_BEATS - 1));

  assign mem_req_addr = {addr_hi, {OFFS{1'b0}}};
  assign mem_req_we   = we_q;

  // Low address bits are discarded by line alignment.
  wire unused_addr_low = ^{ic_addr[OFFS-1:0], dc_addr[OFFS-1:0]};

`ifdef MPS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_active;
  logic            to_progress;

  assign to_active   = (state == REQ) || (state == XFER);
  assign to_progress = ((state == REQ) && mem_req_ready) || beat_fire;
  assign timeout     = to_active && !to_progress &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!to_active || to_progress || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  wire unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt     = state;
    ic_grant      = 1'b0;
    dc_grant      = 1'b0;
    rdata         = '0;
    ic_rvalid     = 1'b0;
    dc_rvalid     = 1'b0;
    dc_wready     = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    mem_req_valid = 1'b0;
    mem_wdata     = '0;
    mem_wvalid    = 1'b0;
    err           = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) state_nxt = REQ;
      end
      REQ: begin
        ic_grant      = (owner == OWN_IC);
        dc_grant      = (owner == OWN_DC);
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = XFER;
      end
      XFER: begin
        ic_grant = (owner == OWN_IC);
        dc_grant = (owner == OWN_DC);
        if (we_q) begin
          mem_wvalid = 1'b1;
          mem_wdata  = dc_wdata;
          dc_wready  = mem_wready;
        end else begin
          rdata     = mem_rdata;
          ic_rvalid = mem_rvalid && (owner == OWN_IC);
          dc_rvalid = mem_rvalid && (owner == OWN_DC);
        end
        if (beat_fire && last_beat) state_nxt = DONE;
      end
      DONE: begin
        ic_done   = (owner == OWN_IC);
        dc_done   = (owner == OWN_DC);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog abort completes the burst as far as the owner is concerned.
    if (timeout) begin
      state_nxt = IDLE;
      err       = 1'b1;
      ic_done   = (owner == OWN_IC);
      dc_done   = (owner == OWN_DC);
    end
  end

  // Transaction context and beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= OWN_IC;
      last_owner <= OWN_DC;
      we_q       <= 1'b0;
      addr_hi    <= '0;
      beat_cnt   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner   <= pick;
        addr_hi <= (pick == OWN_IC) ? ic_addr[ADDR_W-1:OFFS]
                                    : dc_addr[ADDR_W-1:OFFS];
        we_q    <= (pick == OWN_DC) && dc_we;
      end
      if (state == REQ && mem_req_ready) begin
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (state == DONE || timeout) begin
        last_owner <= owner;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_scheduler.sv
// ============================================================================
// Module   : tb_mem_port_scheduler
// Purpose  : Directed self-checking bench for mem_port_scheduler: single
//            fill, tie-break after reset, round-robin over four bursts,
//            gapped read beats, and asynchronous reset mid-burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, dc_req, dc_we;
  logic [63:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_grant, dc_grant, ic_rvalid, dc_rvalid, dc_wready;
  logic        ic_done, dc_done, mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] rdata, mem_req_addr, mem_wdata, mem_rdata;
  logic        mem_wvalid, mem_wready, mem_rvalid, err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .dc_req        (dc_req),
    .dc_we         (dc_we),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .ic_grant      (ic_grant),
    .dc_grant      (dc_grant),
    .rdata         (rdata),
    .ic_rvalid     (ic_rvalid),
    .dc_rvalid     (dc_rvalid),
    .dc_wready     (dc_wready),
    .ic_done       (ic_done),
    .dc_done       (dc_done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_wdata     (mem_wdata),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {53'd0, ic_grant, dc_grant, ic_rvalid, dc_rvalid, dc_wready,
                          ic_done, dc_done, mem_req_valid, mem_req_we, mem_wvalid, err}, 64'd0);
    check({tag, "_rdata"}, rdata, 64'd0);
    check({tag, "_wdata"}, mem_wdata, 64'd0);
    check({tag, "_addr"}, mem_req_addr, 64'd0);
  endtask

  // Serve one burst for the expected owner; gappy inserts idle cycles between beats.
  task automatic burst(input bit is_ic, input bit we, input logic [63:0] exp_addr,
                       input logic [63:0] dbase, input bit gappy);
    int gaps [8];
    int waited;
    gaps   = '{0, 2, 0, 4, 1, 0, 3, 0};
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(is_ic ? ic_grant : dc_grant) && waited < 20);
    check("grant", {63'd0, (is_ic ? ic_grant : dc_grant)}, 64'd1);
    check("other_grant", {63'd0, (is_ic ? dc_grant : ic_grant)}, 64'd0);
    check("req_valid", {63'd0, mem_req_valid}, 64'd1);
    check("req_addr", mem_req_addr, exp_addr);
    check("req_we", {63'd0, mem_req_we}, {63'd0, we});
    // a beat before the request is accepted must not be forwarded
    mem_rvalid = 1'b1;
    #1 check("stray_rvalid", {62'd0, ic_rvalid, dc_rvalid}, 64'd0);
    mem_rvalid    = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_valid_drop", {63'd0, mem_req_valid}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (gappy ? gaps[i] : 0); g++) begin
        #1 check("gap_done", {62'd0, ic_done, dc_done}, 64'd0);
        @(negedge clk);
      end
      if (we) begin
        dc_wdata   = dbase + 64'(i);
        mem_wready = 1'b1;
        #1;
        check("wready", {62'd0, mem_wvalid, dc_wready}, 64'd3);
        check("wdata", mem_wdata, dbase + 64'(i));
      end else begin
        mem_rdata  = dbase + 64'(i);
        mem_rvalid = 1'b1;
        #1;
        check("rvalid", {62'd0, ic_rvalid, dc_rvalid}, is_ic ? 64'd2 : 64'd1);
        check("rdata", rdata, dbase + 64'(i));
      end
      check("xfer_other_grant", {63'd0, (is_ic ? dc_grant : ic_grant)}, 64'd0);
      check("early_done", {62'd0, ic_done, dc_done}, 64'd0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_wready = 1'b0;
    end
    #1;
    check("done", {62'd0, ic_done, dc_done}, is_ic ? 64'd2 : 64'd1);
    check("done_grants", {61'd0, ic_grant, dc_grant, err}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = 64'd0; dc_addr = 64'd0; dc_wdata = 64'hFFFF_0000_FFFF_0000;
    mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // single I-cache fill
    ic_req  = 1'b1;
    ic_addr = 64'h8000_0040;
    burst(1'b1, 1'b0, 64'h8000_0040, 64'hA100_0000, 1'b0);
    ic_req = 1'b0;
    @(negedge clk);
    check("post_idle_grant", {62'd0, ic_grant, dc_grant}, 64'd0);

    // simultaneous requests straight after reset: I-cache first, then writeback
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    dc_we   = 1'b1;
    dc_addr = 64'h0000_1234_5678_9ABC;
    burst(1'b1, 1'b0, 64'h8000_0040, 64'hA200_0000, 1'b0);
    ic_req = 1'b0;
    burst(1'b0, 1'b1, 64'h0000_1234_5678_9A80, 64'hD000_0000, 1'b0);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    @(negedge clk);

    // both held across four bursts: IC, DC (gapped beats), IC, DC
    ic_req = 1'b1;
    dc_req = 1'b1;
    burst(1'b1, 1'b0, 64'h8000_0040, 64'hB100_0000, 1'b0);
    burst(1'b0, 1'b0, 64'h0000_1234_5678_9A80, 64'hB200_0000, 1'b1);
    burst(1'b1, 1'b0, 64'h8000_0040, 64'hB300_0000, 1'b0);
    burst(1'b0, 1'b0, 64'h0000_1234_5678_9A80, 64'hB400_0000, 1'b0);
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // asynchronous reset during beat 3 of a D-cache fill
    dc_req = 1'b1;
    begin
      int waited;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!dc_grant && waited < 20);
      check("t5_grant", {63'd0, dc_grant}, 64'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem_rdata  = 64'hC000_0000 + 64'(i);
        mem_rvalid = 1'b1;
        @(negedge clk);
      end
    end
    mem_rdata  = 64'hC000_0003;
    mem_rvalid = 1'b1;
    dc_wdata   = 64'h5555_AAAA;
    reset      = 1'b1;
    #1 check_quiet("mid_reset");
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("reset_no_done", {62'd0, ic_done, dc_done}, 64'd0);
    ic_req  = 1'b1;
    ic_addr = 64'h8000_0040;
    reset   = 1'b0;
    burst(1'b1, 1'b0, 64'h8000_0040, 64'hE100_0000, 1'b0);
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("final_idle", {62'd0, ic_grant, dc_grant}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Shares the single main-memory port between the I-cache (line fills) and the D-cache (line fills and dirty-line writebacks).
- Holds a grant for the whole multi-beat burst and counts beats.
- Steers read data and write-ready to the owning cache, then pulses done.
- Sits between both cache controllers and the memory/AXI-lite bridge; replaces per-cycle grant toggling with transaction-level round-robin.

Parameters:
ADDR_W, 64, physical address width
DATA_W, 64, memory beat width
LINE_BEATS, 8, beats per cache line (power of two, >=2)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with MPS_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
ic_req  in  1  I-cache line-fill request, level, held until ic_done
ic_addr  in  ADDR_W  I-cache line address, stable while ic_req
dc_req  in  1  D-cache request, level, held until dc_done
dc_we  in  1  1 = writeback, 0 = fill; stable while dc_req
dc_addr  in  ADDR_W  D-cache line address
dc_wdata  in  DATA_W  writeback beat; advances on dc_wready
ic_grant  out  1  I-cache owns the port (IC_OWN)
dc_grant  out  1  D-cache owns the port (DC_OWN)
rdata  out  DATA_W  read beat, shared, qualified by ic_rvalid/dc_rvalid
ic_rvalid  out  1  beat valid for I-cache
dc_rvalid  out  1  beat valid for D-cache
dc_wready  out  1  write beat accepted; D-cache presents the next beat
ic_done  out  1  one-cycle pulse, I-cache burst complete
dc_done  out  1  one-cycle pulse, D-cache burst complete
mem_req_valid  out  1  burst request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  ADDR_W  line-aligned burst address (low log2(LINE_BEATS*DATA_W/8) bits zeroed)
mem_req_we  out  1  burst direction
mem_wdata  out  DATA_W  write beat (= dc_wdata)
mem_wvalid  out  1  write beat valid
mem_wready  in  1  memory accepts the write beat
mem_rdata  in  DATA_W  read beat
mem_rvalid  in  1  read beat valid
err  out  1  one-cycle pulse on watchdog abort (tied 0 without MPS_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0, state IDLE, beat_cnt 0, last_owner = DC, so I-cache wins the first tie.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - Only one requester → select it.
  - Both requesting → select the one that is not last_owner.
  - Register owner, address and direction (I-cache is always a read); move to REQ.
  - Grant asserts the cycle after the request is sampled.
- REQ:
  - mem_req_valid=1, with address and direction held.
  - On mem_req_ready → XFER, beat_cnt=0.
- XFER, read:
  - Each cycle mem_rvalid=1: rdata=mem_rdata (combinational), the owner's rvalid=1, beat_cnt++.
- XFER, write:
  - mem_wvalid=1 continuously.
  - dc_wready = mem_wready.
  - Beat counts on mem_wvalid&&mem_wready.
- Completion: when beat_cnt==LINE_BEATS-1 and a beat transfers → DONE.
- DONE:
  - Owner's done pulses for 1 cycle.
  - last_owner updates.
  - Grant drops.
  - Next state IDLE.
  - Minimum back-to-back gap is one IDLE cycle.
- Grant stability: grant is never revoked mid-burst, even if the owner drops req (protocol violation; the burst still completes).
- Ignored input changes: a requester's req/addr changes while the other owns the port are ignored until IDLE.
- Stray beats: mem_rvalid outside XFER-read is ignored; rvalid is never forwarded to the non-owner.
- Async reset mid-burst: everything returns to reset values immediately; no done pulse; the memory side is responsible for its own flush.

Optional Feature:
MPS_TIMEOUT_EN:
- When defined: a counter in REQ/XFER clears on every handshake/beat.
- Reaching TIMEOUT_CYC-1 forces IDLE, pulses err plus the owner's done, and updates last_owner.
- When undefined: no counter; err is constant 0; the scheduler waits indefinitely.

Decomposition:
- Package mem_sched_pkg: state enum (IDLE/REQ/XFER/DONE), owner enum (OWN_IC/OWN_DC), localparam BEAT_CNT_W = $clog2(LINE_BEATS).
- Sub-module rr_pick2: the two-requester round-robin pick from last_owner.
- All else inline.

Test Plan:
1. ic_req only, addr 0x8000_0040 → mem_req_addr 0x8000_0040, mem_req_we=0; 8 rvalid beats reach ic_rvalid only; ic_done one cycle after the 8th beat.
2. ic_req and dc_req(we=1) same cycle after reset → I-cache served first; then D-cache writeback; 8 dc_wready beats, mem_wdata matches dc_wdata sequence; dc_done.
3. Both held continuously across 4 bursts → grant order IC, DC, IC, DC; no overlap of ic_grant/dc_grant.
4. mem_rvalid gaps (beats at cycles 0,3,4,9,…) → beat_cnt still ends at 8; no early done.
5. Reset asserted at beat 3 of a D-cache fill → all outputs 0 the same cycle; no dc_done; next request re-arbitrates from IC priority.
6. MPS_TIMEOUT_EN, TIMEOUT_CYC=16, mem_req_ready held 0 → err and owner's done pulse at cycle 16 after REQ entry; state IDLE.
